// File: rtl/mc6809_eq_gen_if.sv
// E/Q generator bus bundle: clock-enable and ready inputs, phase/strobe outputs.
// The master side drives CLKEN/MRDY/CYC_CLR; the generator is the slave.
interface mc6809_eq_gen_if #(
  parameter int CNT_W = 16
);
  logic             CLKEN;
  logic             MRDY;
  logic             CYC_CLR;
  logic             E;
  logic             Q;
  logic             riseE;
  logic             fallE;
  logic             riseQ;
  logic             fallQ;
  logic             STRETCHING;
  logic             STRETCH_TO;
  logic [CNT_W-1:0] CYCLES;

  modport master (
    output CLKEN, MRDY, CYC_CLR,
    input  E, Q, riseE, fallE, riseQ, fallQ,
    input  STRETCHING, STRETCH_TO, CYCLES
  );

  modport slave (
    input  CLKEN, MRDY, CYC_CLR,
    output E, Q, riseE, fallE, riseQ, fallQ,
    output STRETCHING, STRETCH_TO, CYCLES
  );
endinterface

// File: rtl/mc6809_eq_gen.sv
// 6809 E/Q quadrature generator with quarter divider and MRDY stretching.
// Define MC6809_EQ_CYCLE_COUNTER_EN to build the CYCLES counter.
module mc6809_eq_gen #(
  parameter int QDIV        = 1,
  parameter int STRETCH_MAX = 10,
  parameter int CNT_W       = 16
) (
  input logic           CLK,
  input logic           RESET,
  mc6809_eq_gen_if.slave bus
);
  localparam int DW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int SW = (STRETCH_MAX > 0) ? $clog2(STRETCH_MAX + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(QDIV - 1);
  localparam logic [SW-1:0] S_MAX    = SW'(STRETCH_MAX);
  localparam logic          CAN_STR  = (STRETCH_MAX > 0);

  typedef enum logic [1:0] {
    PH_FALLE,
    PH_RISEQ,
    PH_RISEE,
    PH_FALLQ
  } phase_t;

  phase_t        phase, phaseNx;
  logic [DW-1:0] divCnt, divNx;
  logic [SW-1:0] sCnt, sCntNx;
  logic          eReg, eNx;
  logic          qReg, qNx;
  logic          fallEReg, fallENx;
  logic          riseQReg, riseQNx;
  logic          riseEReg, riseENx;
  logic          fallQReg, fallQNx;
  logic          strReg, strNx;
  logic          toReg, toNx;
  logic          tick;
  logic          hold;

  assign tick = bus.CLKEN && (divCnt == DIV_LAST);
  assign hold = !bus.MRDY && (sCnt < S_MAX);

  always_comb begin
    phaseNx = phase;
    divNx   = divCnt;
    sCntNx  = sCnt;
    eNx     = eReg;
    qNx     = qReg;
    fallENx = 1'b0;
    riseQNx = 1'b0;
    riseENx = 1'b0;
    fallQNx = 1'b0;
    strNx   = strReg;
    toNx    = 1'b0;
    if (bus.CLKEN)
      divNx = tick ? '0 : divCnt + 1'b1;
    if (tick) begin
      unique case (1'b1)
        (phase == PH_FALLE): begin
          // MRDY low holds E high for one more quarter
          if (hold) begin
            sCntNx = sCnt + 1'b1;
            strNx  = 1'b1;
          end else begin
            eNx     = 1'b0;
            fallENx = 1'b1;
            phaseNx = PH_RISEQ;
            sCntNx  = '0;
            strNx   = 1'b0;
            toNx    = !bus.MRDY && CAN_STR;
          end
        end
        (phase == PH_RISEQ): begin
          qNx     = 1'b1;
          riseQNx = 1'b1;
          phaseNx = PH_RISEE;
        end
        (phase == PH_RISEE): begin
          eNx     = 1'b1;
          riseENx = 1'b1;
          phaseNx = PH_FALLQ;
        end
        default: begin
          qNx     = 1'b0;
          fallQNx = 1'b1;
          phaseNx = PH_FALLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase    <= PH_FALLE;
      divCnt   <= '0;
      sCnt     <= '0;
      eReg     <= 1'b1;
      qReg     <= 1'b0;
      fallEReg <= 1'b0;
      riseQReg <= 1'b0;
      riseEReg <= 1'b0;
      fallQReg <= 1'b0;
      strReg   <= 1'b0;
      toReg    <= 1'b0;
    end else begin
      phase    <= phaseNx;
      divCnt   <= divNx;
      sCnt     <= sCntNx;
      eReg     <= eNx;
      qReg     <= qNx;
      fallEReg <= fallENx;
      riseQReg <= riseQNx;
      riseEReg <= riseENx;
      fallQReg <= fallQNx;
      strReg   <= strNx;
      toReg    <= toNx;
    end
  end

  assign bus.E          = eReg;
  assign bus.Q          = qReg;
  assign bus.fallE      = fallEReg;
  assign bus.riseQ      = riseQReg;
  assign bus.riseE      = riseEReg;
  assign bus.fallQ      = fallQReg;
  assign bus.STRETCHING = strReg;
  assign bus.STRETCH_TO = toReg;

`ifdef MC6809_EQ_CYCLE_COUNTER_EN
  logic [CNT_W-1:0] cycCnt;

  always_ff @(posedge CLK) begin
    if (RESET || bus.CYC_CLR)
      cycCnt <= '0;
    else if (fallENx)
      cycCnt <= cycCnt + CNT_W'(1);
  end

  assign bus.CYCLES = cycCnt;
`else
  logic unusedCycClr;

  assign unusedCycClr = bus.CYC_CLR;
  assign bus.CYCLES   = '0;
`endif
endmodule

// File: tb/tb_mc6809_eq_gen.sv
// Bench for mc6809_eq_gen: vector table, corner sequences, random vs model.
// DUT A: QDIV=1 STRETCH_MAX=2 CNT_W=4; DUT B: QDIV=3 STRETCH_MAX=10.
module tb_mc6809_eq_gen;
  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  mc6809_eq_gen_if #(.CNT_W(4))  ifA ();
  mc6809_eq_gen_if #(.CNT_W(16)) ifB ();

  mc6809_eq_gen #(.QDIV(1), .STRETCH_MAX(2), .CNT_W(4)) dutA (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (ifA)
  );

  mc6809_eq_gen #(.QDIV(3), .STRETCH_MAX(10), .CNT_W(16)) dutB (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (ifB)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase index p; E/Q are a function of the phase just entered.
  int QD[2] = '{1, 3};
  int SM[2] = '{2, 10};
  int CW[2] = '{4, 16};
  int mPh[2], mDiv[2], mSc[2], mE[2], mQ[2];
  int mStb[2], mStr[2], mTo[2], mCyc[2];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic modelStep(int k, bit rst, bit ce, bit rdy, bit clr);
    bit tick;
    int old;
    if (rst) begin
      mPh[k] = 0; mDiv[k] = 0; mSc[k] = 0;
      mE[k] = 1; mQ[k] = 0;
      mStb[k] = 0; mStr[k] = 0; mTo[k] = 0; mCyc[k] = 0;
      return;
    end
    mStb[k] = 0;
    mTo[k] = 0;
    tick = 0;
    if (ce) begin
      mDiv[k]++;
      if (mDiv[k] == QD[k]) begin
        mDiv[k] = 0;
        tick = 1;
      end
    end
    if (tick) begin
      if (mPh[k] == 0 && !rdy && mSc[k] < SM[k]) begin
        mSc[k]++;
        mStr[k] = 1;
      end else begin
        old = mPh[k];
        mStb[k] = 8 >> old;
        if (old == 0) begin
          mTo[k] = (!rdy && SM[k] > 0) ? 1 : 0;
          mSc[k] = 0;
          mStr[k] = 0;
        end
        mPh[k] = (old + 1) % 4;
        mE[k] = (mPh[k] == 0 || mPh[k] == 3) ? 1 : 0;
        mQ[k] = (mPh[k] >= 2) ? 1 : 0;
      end
    end
`ifdef MC6809_EQ_CYCLE_COUNTER_EN
    if (clr) mCyc[k] = 0;
    else if (mStb[k] == 8) mCyc[k] = (mCyc[k] + 1) % (1 << CW[k]);
`else
    if (clr) mCyc[k] = 0;
`endif
  endtask

  task automatic cmp(int k, logic e, logic q, logic [3:0] stb,
                     logic str, logic to, logic [31:0] cyc);
    string p;
    p = (k == 0) ? "A" : "B";
    chk({p, ".E"}, 32'(e), 32'(mE[k]));
    chk({p, ".Q"}, 32'(q), 32'(mQ[k]));
    chk({p, ".strobes"}, 32'(stb), 32'(mStb[k]));
    chk({p, ".STRETCHING"}, 32'(str), 32'(mStr[k]));
    chk({p, ".STRETCH_TO"}, 32'(to), 32'(mTo[k]));
    chk({p, ".CYCLES"}, cyc, 32'(mCyc[k]));
    chk({p, ".onehot"}, 32'($countones(stb) <= 1), 32'd1);
  endtask

  task automatic cycle();
    @(posedge CLK);
    modelStep(0, RESET, ifA.CLKEN, ifA.MRDY, ifA.CYC_CLR);
    modelStep(1, RESET, ifB.CLKEN, ifB.MRDY, ifB.CYC_CLR);
    #1;
    cmp(0, ifA.E, ifA.Q, {ifA.fallE, ifA.riseQ, ifA.riseE, ifA.fallQ},
        ifA.STRETCHING, ifA.STRETCH_TO, 32'(ifA.CYCLES));
    cmp(1, ifB.E, ifB.Q, {ifB.fallE, ifB.riseQ, ifB.riseE, ifB.fallQ},
        ifB.STRETCHING, ifB.STRETCH_TO, 32'(ifB.CYCLES));
  endtask

  typedef struct {
    bit       rst, ce, rdy;
    bit       e, q;
    bit [3:0] stb;
    bit       str, to;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int n;
    bit found, sawTo;
    int expCyc;

    // {rst,ce,rdy, E,Q, {fallE,riseQ,riseE,fallQ}, STRETCHING, STRETCH_TO}
    tbl[0]  = '{1, 1, 1, 1, 0, 4'b0000, 0, 0};
    tbl[1]  = '{0, 1, 1, 0, 0, 4'b1000, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 1, 4'b0100, 0, 0};
    tbl[3]  = '{0, 1, 1, 1, 1, 4'b0010, 0, 0};
    tbl[4]  = '{0, 1, 1, 1, 0, 4'b0001, 0, 0};
    tbl[5]  = '{0, 0, 1, 1, 0, 4'b0000, 0, 0};
    tbl[6]  = '{0, 1, 0, 1, 0, 4'b0000, 1, 0};
    tbl[7]  = '{0, 1, 0, 1, 0, 4'b0000, 1, 0};
    tbl[8]  = '{0, 1, 0, 0, 0, 4'b1000, 0, 1};
    tbl[9]  = '{0, 1, 0, 0, 1, 4'b0100, 0, 0};
    tbl[10] = '{0, 1, 0, 1, 1, 4'b0010, 0, 0};
    tbl[11] = '{0, 0, 0, 1, 1, 4'b0000, 0, 0};
    tbl[12] = '{0, 1, 0, 1, 0, 4'b0001, 0, 0};
    tbl[13] = '{0, 1, 0, 1, 0, 4'b0000, 1, 0};
    tbl[14] = '{0, 1, 1, 0, 0, 4'b1000, 0, 0};
    tbl[15] = '{1, 1, 1, 1, 0, 4'b0000, 0, 0};

    RESET = 1'b1;
    ifA.CLKEN = 1'b1; ifA.MRDY = 1'b1; ifA.CYC_CLR = 1'b0;
    ifB.CLKEN = 1'b1; ifB.MRDY = 1'b1; ifB.CYC_CLR = 1'b0;

    for (int i = 0; i < 16; i++) begin
      RESET = tbl[i].rst;
      ifA.CLKEN = tbl[i].ce;
      ifA.MRDY = tbl[i].rdy;
      cycle();
      chk($sformatf("tbl%0d.E", i), 32'(ifA.E), 32'(tbl[i].e));
      chk($sformatf("tbl%0d.Q", i), 32'(ifA.Q), 32'(tbl[i].q));
      chk($sformatf("tbl%0d.stb", i),
          32'({ifA.fallE, ifA.riseQ, ifA.riseE, ifA.fallQ}), 32'(tbl[i].stb));
      chk($sformatf("tbl%0d.STRETCHING", i), 32'(ifA.STRETCHING), 32'(tbl[i].str));
      chk($sformatf("tbl%0d.STRETCH_TO", i), 32'(ifA.STRETCH_TO), 32'(tbl[i].to));
    end

    // 17 fallE strobes wrap a 4-bit counter to 1; clear beats increment.
    RESET = 1'b0;
    ifA.CLKEN = 1'b1; ifA.MRDY = 1'b1;
    n = 0;
    for (int i = 0; i < 68; i++) begin
      cycle();
      if (ifA.fallE) n++;
    end
`ifdef MC6809_EQ_CYCLE_COUNTER_EN
    expCyc = 1;
`else
    expCyc = 0;
`endif
    chk("wrap.fallE_count", 32'(n), 32'd17);
    chk("wrap.CYCLES", 32'(ifA.CYCLES), 32'(expCyc));
    ifA.CYC_CLR = 1'b1;
    cycle();
    chk("clr.fallE", 32'(ifA.fallE), 32'd1);
    chk("clr.CYCLES", 32'(ifA.CYCLES), 32'd0);
    ifA.CYC_CLR = 1'b0;

    // QDIV=3 with CLKEN every other clock: one strobe per 6 clocks.
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    for (int i = 0; i < 48; i++) begin
      ifB.CLKEN = (i % 2 == 0);
      cycle();
      chk($sformatf("div.strobe%0d", i),
          32'(ifB.fallE | ifB.riseQ | ifB.riseE | ifB.fallQ),
          32'(i % 6 == 4));
    end

    // Three stretched quarters, then release.
    ifB.CLKEN = 1'b1; ifB.MRDY = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      found = ifB.fallQ;
    end
    chk("str.fallQ_found", 32'(found), 32'd1);
    ifB.MRDY = 1'b0;
    sawTo = 0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      sawTo |= ifB.STRETCH_TO;
      chk($sformatf("str.E%0d", i), 32'(ifB.E), 32'd1);
      chk($sformatf("str.noFallE%0d", i), 32'(ifB.fallE), 32'd0);
    end
    chk("str.STRETCHING", 32'(ifB.STRETCHING), 32'd1);
    ifB.MRDY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      sawTo |= ifB.STRETCH_TO;
      chk($sformatf("rel.fallE%0d", i), 32'(ifB.fallE), 32'(i == 2));
    end
    chk("rel.STRETCHING", 32'(ifB.STRETCHING), 32'd0);
    chk("rel.noTimeout", 32'(sawTo), 32'd0);

    // Reset while stretching.
    ifB.MRDY = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      found = ifB.STRETCHING;
    end
    chk("rst.stretch_found", 32'(found), 32'd1);
    RESET = 1'b1;
    cycle();
    chk("rst.E", 32'(ifB.E), 32'd1);
    chk("rst.Q", 32'(ifB.Q), 32'd0);
    chk("rst.STRETCHING", 32'(ifB.STRETCHING), 32'd0);
    chk("rst.CYCLES", 32'(ifB.CYCLES), 32'd0);
    RESET = 1'b0;
    ifB.MRDY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("rst.fallE%0d", i), 32'(ifB.fallE), 32'(i == 2));
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      RESET = ($urandom_range(0, 149) == 0);
      ifA.CLKEN = ($urandom_range(0, 3) != 0);
      ifA.MRDY = ($urandom_range(0, 2) != 0);
      ifA.CYC_CLR = ($urandom_range(0, 63) == 0);
      ifB.CLKEN = ($urandom_range(0, 3) != 0);
      ifB.MRDY = ($urandom_range(0, 3) != 0);
      ifB.CYC_CLR = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
